// File: rtl/dbus_if.sv
// Data-bus interface between the memory stage and a Wishbone-style bus.
// One outstanding access at a time, with a bus-cycle timeout abort and a hold state for a stalled pipeline.
module dbus_if #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        cpu_ce_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [3:0]  cpu_sel_i,
   input  logic [31:0] cpu_data_i,
   output logic [31:0] cpu_data_o,
   output logic        stallreq_o,
   output logic        bus_err_o,
   output logic        bus_cyc_o,
   output logic        bus_stb_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_data_o,
   input  logic [31:0] bus_data_i,
   input  logic        bus_ack_i
);

   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [31:0]   rd_buf;
   logic          accept, done, tmo;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Completion (ack or timeout) wins over stalling; flush and reset silence everything.
   always_comb begin
      state_nxt  = state;
      stallreq_o = 1'b0;
      cpu_data_o = 32'h0;
      bus_err_o  = 1'b0;
      accept     = 1'b0;
      done       = 1'b0;
      tmo        = 1'b0;
      if (rst) begin
         state_nxt = IDLE;
      end else if (flush_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (cpu_ce_i) begin
               accept     = 1'b1;
               stallreq_o = 1'b1;
               state_nxt  = BUSY;
            end
            BUSY: if (bus_ack_i) begin
               done       = 1'b1;
               cpu_data_o = bus_we_o ? 32'h0 : bus_data_i;
               state_nxt  = stall_i ? HOLD : IDLE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               done      = 1'b1;
               tmo       = 1'b1;
               bus_err_o = 1'b1;
               state_nxt = stall_i ? HOLD : IDLE;
            end else begin
               stallreq_o = 1'b1;
            end
            HOLD: begin
               cpu_data_o = rd_buf;
               if (!stall_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_cyc_o  <= 1'b0;
         bus_stb_o  <= 1'b0;
         bus_we_o   <= 1'b0;
         bus_addr_o <= 32'h0;
         bus_sel_o  <= 4'h0;
         bus_data_o <= 32'h0;
         rd_buf     <= 32'h0;
         cnt        <= '0;
      end else if (flush_i) begin
         bus_cyc_o <= 1'b0;
         bus_stb_o <= 1'b0;
         bus_we_o  <= 1'b0;
         cnt       <= '0;
      end else if (accept) begin
         bus_cyc_o  <= 1'b1;
         bus_stb_o  <= 1'b1;
         bus_we_o   <= cpu_we_i;
         bus_addr_o <= cpu_addr_i;
         bus_sel_o  <= cpu_sel_i;
         bus_data_o <= cpu_data_i;
         cnt        <= '0;
      end else if (done) begin
         bus_cyc_o <= 1'b0;
         bus_stb_o <= 1'b0;
         bus_we_o  <= 1'b0;
         bus_sel_o <= 4'h0;
         cnt       <= '0;
         // cpu_data_o already folds in write-returns-zero and timeout-returns-zero.
         rd_buf    <= tmo ? 32'h0 : cpu_data_o;
      end else if (state == BUSY) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule
